// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the RV32I load/store port.
// Accepts one request per handshake, waits a fixed number of cycles, then completes or rejects it.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [2:0]  lat_f3;
  logic [31:0] lat_wdata;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp, wr_en;
  logic        s_we;
  logic [31:0] s_addr;
  logic [2:0]  s_f3;
  logic [31:0] s_wdata;
  logic        bad_f3, misalign, out_of_range, acc_err;
  logic [AW-1:0] idx;
  logic [31:0] cur_word, st_word, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept     = (state_q == S_IDLE) && req;
  assign enter_resp = ((state_q == S_WAIT) && (cnt_q == 4'd0)) || ((WAIT_STATES == 0) && accept);

  // With no wait states the access completes on the acceptance edge, so the live inputs are used.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    s_we    = lat_we;
    s_addr  = lat_addr;
    s_f3    = lat_f3;
    s_wdata = lat_wdata;
    if (state_q == S_IDLE) begin
      s_we    = we;
      s_addr  = addr;
      s_f3    = func3;
      s_wdata = wdata;
    end
  end

  always_comb begin
    bad_f3 = s_we ? (s_f3 > 3'b010) : ((s_f3 == 3'b011) || (s_f3[2:1] == 2'b11));
    unique case (s_f3[1:0])
      2'b01:   misalign = s_addr[0];
      2'b10:   misalign = (s_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    out_of_range = ({2'b00, s_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_err      = bad_f3 || misalign || out_of_range;
  end

  assign idx = s_addr[AW+1:2];

  always_comb begin
    cur_word = mem[idx];
    st_word  = cur_word;
    unique case (s_f3[1:0])
      2'b00:   st_word[{s_addr[1:0], 3'b000} +: 8] = s_wdata[7:0];
      2'b01:   st_word[{s_addr[1], 4'b0000} +: 16] = s_wdata[15:0];
      default: st_word = s_wdata;
    endcase
    ld_byte = cur_word[{s_addr[1:0], 3'b000} +: 8];
    ld_half = cur_word[{s_addr[1], 4'b0000} +: 16];
    unique case (s_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = cur_word;
    endcase
  end

  // Gating with rst keeps a store from landing on a clock edge seen while reset is held.
  assign wr_en = rst && enter_resp && s_we && !acc_err;

  // NOTE: the storage array has no reset; clearing it would force flops instead of a RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= st_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_f3    <= 3'd0;
      lat_wdata <= 32'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_f3    <= func3;
        lat_wdata <= wdata;
      end
      if (enter_resp) begin
        err_q <= acc_err;
        if (!s_we && !acc_err) rdata_q <= ld_val;
      end else begin
        err_q <= 1'b0;
      end
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_RESP);
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule
